// File: rtl/adder_pkg.sv
// adder_pkg: shared adder width default and a constant-safe clog2 used for derived widths
package adder_pkg;
  localparam int ADDER_WIDTH_DEF = 118;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator: sums BLOCK_LEN valid adder results (or fewer on flush) into res_total/res_count on a valid/ready port, never stalls input, flags overwritten results via sticky overrun
module adder_sum_accumulator
  import adder_pkg::*;
#(
  parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
  parameter int BLOCK_LEN   = 16,
  localparam int SUM_W = ADDER_WIDTH + 1,
  localparam int CNT_W = clog2(BLOCK_LEN + 1),
  localparam int ACC_W = SUM_W + clog2(BLOCK_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sum_valid,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_total,
  output logic [CNT_W-1:0] res_count,
  output logic             overrun
);
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             close;
  always_comb begin
    acc_n = acc + (sum_valid ? ACC_W'(sum_in) : '0);
    cnt_n = cnt + CNT_W'(sum_valid);
    close = (sum_valid && cnt == CNT_W'(BLOCK_LEN - 1)) || (flush && (cnt != '0 || sum_valid));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_total <= '0;
      res_count <= '0;
      overrun   <= 1'b0;
    end else if (close) begin
      acc       <= '0;
      cnt       <= '0;
      res_valid <= 1'b1;
      res_total <= acc_n;
      res_count <= cnt_n;
      overrun   <= overrun | (res_valid & ~res_ready);
    end else begin
      acc       <= acc_n;
      cnt       <= cnt_n;
      res_valid <= res_valid & ~res_ready;
    end
  end
endmodule
